// File: rtl/measure_control.sv
// Latency-measurement sequencer: arms on enable, times start_trigger to
// sensor_trigger, enforces a timeout and a hold-off, and tracks the
// position within the averaging window.
//
// Optional feature: define MEASURE_CONTROL_STATS_EN to build the
// saturating timeout_count; otherwise timeout_count is tied to 0.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable              level; measurement runs only while high
//   start_trigger       pulse, test pattern started
//   sensor_trigger      pulse, photo sensor edge seen
//   config_changed      pulse, resolution changed
//   counter_clear       pulse, zero the latency counter
//   counter_enable      level, latency counter runs (MEASURE only)
//   sample_latch        pulse, store counter as current sample
//   avg_strobe          pulse, averaging window complete
//   accum_clear         pulse, clear min/max/avg accumulators
//   timeout             pulse, missed sample
//   state               IDLE=0 ARMED=1 MEASURE=2 HOLDOFF=3
//   sample_index        position within the averaging window
//   timeout_count       saturating count of missed samples
module measure_control #(
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd8_000_000,
  parameter logic [15:0] HOLDOFF_CYCLES   = 16'd1000,
  parameter int          AVG_SAMPLES_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       start_trigger,
  input  logic       sensor_trigger,
  input  logic       config_changed,
  output logic       counter_clear,
  output logic       counter_enable,
  output logic       sample_latch,
  output logic       avg_strobe,
  output logic       accum_clear,
  output logic       timeout,
  output logic [1:0] state,
  output logic [3:0] sample_index,
  output logic [7:0] timeout_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam logic [3:0] IDX_LAST =
    4'((1 << AVG_SAMPLES_LOG2) - 1);

  logic [1:0]  state_d;
  logic [23:0] tcnt_q, tcnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [3:0]  sidx_d;
  logic        init_q;
  logic        clr_d, cen_d, lat_d;
  logic        avg_d, aclr_d, tout_d;

  logic run, idx_last, tmo_hit, hold_done;

  // Normal transitions apply only when neither config_changed
  // nor a low enable takes priority.
  assign run       = !config_changed && enable;
  assign idx_last  = (sample_index == IDX_LAST);
  assign tmo_hit   = (tcnt_q == TIMEOUT_CYCLES - 24'd1);
  assign hold_done = (hcnt_q == HOLDOFF_CYCLES - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      tcnt_q         <= '0;
      hcnt_q         <= '0;
      sample_index   <= '0;
      init_q         <= 1'b1;
      counter_clear  <= 1'b0;
      counter_enable <= 1'b0;
      sample_latch   <= 1'b0;
      avg_strobe     <= 1'b0;
      accum_clear    <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_d;
      tcnt_q         <= tcnt_d;
      hcnt_q         <= hcnt_d;
      sample_index   <= sidx_d;
      init_q         <= 1'b0;
      counter_clear  <= clr_d;
      counter_enable <= cen_d;
      sample_latch   <= lat_d;
      avg_strobe     <= avg_d;
      accum_clear    <= aclr_d;
      timeout        <= tout_d;
    end
  end

  always_comb begin
    state_d = state;
    tcnt_d  = tcnt_q;
    hcnt_d  = hcnt_q;
    sidx_d  = sample_index;
    if (config_changed) begin
      state_d = enable ? ARMED : IDLE;
      tcnt_d  = '0;
      hcnt_d  = '0;
      sidx_d  = '0;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (start_trigger) begin
            state_d = MEASURE;
            tcnt_d  = '0;
          end
        end
        MEASURE: begin
          if (sensor_trigger) begin
            state_d = HOLDOFF;
            hcnt_d  = '0;
            sidx_d  = idx_last ? 4'd0
                               : sample_index + 4'd1;
          end else if (tmo_hit) begin
            state_d = HOLDOFF;
            hcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 24'd1;
          end
        end
        HOLDOFF: begin
          if (hold_done) state_d = ARMED;
          else           hcnt_d  = hcnt_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    clr_d  = 1'b0;
    lat_d  = 1'b0;
    avg_d  = 1'b0;
    tout_d = 1'b0;
    cen_d  = (state_d == MEASURE);
    // init_q carries the post-reset accumulator clear.
    aclr_d = init_q || config_changed;
    if (run) begin
      unique case (state)
        ARMED: clr_d = start_trigger;
        MEASURE: begin
          lat_d  = sensor_trigger;
          avg_d  = sensor_trigger && idx_last;
          tout_d = !sensor_trigger && tmo_hit;
        end
        default: ;
      endcase
    end
  end

`ifdef MEASURE_CONTROL_STATS_EN
  logic [7:0] tocnt_q;

  always_ff @(posedge clock) begin
    if (reset || config_changed) begin
      tocnt_q <= '0;
    end else if (tout_d && tocnt_q != 8'hff) begin
      tocnt_q <= tocnt_q + 8'd1;
    end
  end

  assign timeout_count = tocnt_q;
`else
  assign timeout_count = 8'd0;
`endif

endmodule
